// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// vga_plot_arbiter : round-robin arbiter granting one of three pixel sources
//                    exclusive bursts onto a single VGA adapter write port.
// Revision 1.0
// ============================================================================
module vga_plot_arbiter #(
  parameter int unsigned XMAX    = 159,
  parameter int unsigned YMAX    = 119,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  valid,
  input  logic [2:0]  last,
  input  logic [23:0] x_in,
  input  logic [20:0] y_in,
  input  logic [8:0]  color_in,
  output logic [2:0]  gnt,
  output logic        plot,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  color,
  output logic        busy,
  output logic [7:0]  drop_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);
  localparam logic [7:0]    c_xmax    = 8'(XMAX);
  localparam logic [6:0]    c_ymax    = 7'(YMAX);

  state_t          state_q, state_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [1:0]      prio_q, prio_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            plot_q, plot_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [2:0]      color_q, color_d;
  logic [7:0]      drop_q, drop_d;

  logic [1:0]      cur_idx;
  logic [1:0]      next_prio;
  logic [7:0]      sel_x;
  logic [6:0]      sel_y;
  logic [2:0]      sel_color;
  logic            sel_req, sel_valid, sel_last;
  logic            in_range;
  logic [2:0]      req_rot;
  logic [1:0]      pick_off;
  logic [2:0]      pick_sum;
  logic [1:0]      pick_idx;
  logic [CW-1:0]   idle_inc;

  // Requester fields are muxed from the currently held grant only.
  always_comb begin
    cur_idx = gnt_q[2] ? 2'd2 : (gnt_q[1] ? 2'd1 : 2'd0);
    case (cur_idx)
      2'd1:    begin sel_x = x_in[15:8];  sel_y = y_in[13:7];  sel_color = color_in[5:3]; end
      2'd2:    begin sel_x = x_in[23:16]; sel_y = y_in[20:14]; sel_color = color_in[8:6]; end
      default: begin sel_x = x_in[7:0];   sel_y = y_in[6:0];   sel_color = color_in[2:0]; end
    endcase
    sel_req   = req[cur_idx];
    sel_valid = valid[cur_idx];
    sel_last  = last[cur_idx];
    in_range  = (sel_x <= c_xmax) && (sel_y <= c_ymax);
    next_prio = (cur_idx == 2'd2) ? 2'd0 : cur_idx + 2'd1;
    idle_inc  = idle_cnt_q + CW'(1);
  end

  // Rotate requests so bit 0 is the current highest priority, then take the first set bit.
  always_comb begin
    case (prio_q)
      2'd1:    req_rot = {req[0], req[2:1]};
      2'd2:    req_rot = {req[1:0], req[2]};
      default: req_rot = req;
    endcase
    pick_off = req_rot[0] ? 2'd0 : (req_rot[1] ? 2'd1 : 2'd2);
    pick_sum = {1'b0, prio_q} + {1'b0, pick_off};
    pick_idx = (pick_sum >= 3'd3) ? 2'(pick_sum - 3'd3) : pick_sum[1:0];
  end

  always_comb begin
    logic take;
    logic release_gnt;
    state_d     = state_q;
    gnt_d       = gnt_q;
    prio_d      = prio_q;
    idle_cnt_d  = idle_cnt_q;
    plot_d      = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    color_d     = color_q;
    drop_d      = drop_q;
    take        = 1'b0;
    release_gnt = 1'b0;

    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 3'b001 << pick_idx;
        end
      end
      GRANT: begin
        // A final pixel wins over a simultaneous request drop.
        if (sel_valid && sel_last) begin
          take        = 1'b1;
          release_gnt = 1'b1;
        end else if (!sel_req) begin
          release_gnt = 1'b1;
        end else if (sel_valid) begin
          take       = 1'b1;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_inc;
          if (idle_inc == c_timeout) begin
            release_gnt = 1'b1;
          end
        end

        if (take) begin
          if (in_range) begin
            plot_d  = 1'b1;
            x_d     = sel_x;
            y_d     = sel_y;
            color_d = sel_color;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end

        if (release_gnt) begin
          state_d    = IDLE;
          gnt_d      = 3'b000;
          idle_cnt_d = '0;
          prio_d     = next_prio;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 3'b000;
      prio_q     <= 2'd0;
      idle_cnt_q <= '0;
      plot_q     <= 1'b0;
      x_q        <= 8'd0;
      y_q        <= 7'd0;
      color_q    <= 3'd0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      prio_q     <= prio_d;
      idle_cnt_q <= idle_cnt_d;
      plot_q     <= plot_d;
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
      drop_q     <= drop_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = |gnt_q;
  assign plot       = plot_q;
  assign x          = x_q;
  assign y          = y_q;
  assign color      = color_q;
  assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vga_plot_arbiter : directed self-checking bench for vga_plot_arbiter.
// Revision 1.0
// ============================================================================
module tb_vga_plot_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, valid, last;
  logic [7:0]  px [3];
  logic [6:0]  py [3];
  logic [2:0]  pc [3];
  logic [23:0] x_in;
  logic [20:0] y_in;
  logic [8:0]  color_in;
  logic [2:0]  gnt;
  logic        plot;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  color_out;
  logic        busy;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  assign x_in     = {px[2], px[1], px[0]};
  assign y_in     = {py[2], py[1], py[0]};
  assign color_in = {pc[2], pc[1], pc[0]};

  always #5 clk = ~clk;

  vga_plot_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .valid      (valid),
    .last       (last),
    .x_in       (x_in),
    .y_in       (y_in),
    .color_in   (color_in),
    .gnt        (gnt),
    .plot       (plot),
    .x          (x_out),
    .y          (y_out),
    .color      (color_out),
    .busy       (busy),
    .drop_count (drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_gnt"},   gnt,        0);
    check({tag, "_plot"},  plot,       0);
    check({tag, "_x"},     x_out,      0);
    check({tag, "_y"},     y_out,      0);
    check({tag, "_color"}, color_out,  0);
    check({tag, "_busy"},  busy,       0);
    check({tag, "_drop"},  drop_count, 0);
  endtask

  initial begin
    int n_plot;
    int bad_pix;
    int bad_gnt;

    reset = 1'b1; req = '0; valid = '0; last = '0;
    for (int i = 0; i < 3; i++) begin px[i] = '0; py[i] = '0; pc[i] = '0; end
    tick(); tick();
    check_zero_outputs("reset");
    reset = 1'b0;

    // Full-screen sweep by requester 0.
    req = 3'b001;
    tick();
    check("sweep_grant", gnt, 3'b001);
    check("sweep_busy", busy, 1);
    n_plot = 0; bad_pix = 0; bad_gnt = 0;
    for (int yi = 0; yi < 120; yi++) begin
      for (int xi = 0; xi < 160; xi++) begin
        px[0] = 8'(xi); py[0] = 7'(yi); pc[0] = 3'((xi + yi) % 8);
        valid = 3'b001;
        last  = (xi == 159 && yi == 119) ? 3'b001 : 3'b000;
        if (gnt !== 3'b001) bad_gnt++;
        tick();
        if (plot === 1'b1) n_plot++;
        if (plot !== 1'b1 || x_out !== 8'(xi) || y_out !== 7'(yi) || color_out !== 3'((xi + yi) % 8))
          bad_pix++;
      end
    end
    check("sweep_pulses", n_plot, 19200);
    check("sweep_pixel_err", bad_pix, 0);
    check("sweep_gnt_held", bad_gnt, 0);
    check("sweep_end_gnt", gnt, 3'b000);
    valid = '0; last = '0; req = '0;
    tick();
    check("hold_plot", plot, 0);
    check("hold_x", x_out, 159);
    check("hold_y", y_out, 119);

    // Round-robin with single-pixel bursts, starting from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    px[0] = 8'd10; py[0] = 7'd20; pc[0] = 3'd1;
    px[1] = 8'd30; py[1] = 7'd40; pc[1] = 3'd2;
    px[2] = 8'd50; py[2] = 7'd60; pc[2] = 3'd3;
    req = 3'b111; valid = 3'b111; last = 3'b111;
    tick(); check("rr_g1", gnt, 3'b001);
    tick(); check("rr_gap1", gnt, 3'b000); check("rr_px0", x_out, 10); check("rr_plot0", plot, 1);
    tick(); check("rr_g2", gnt, 3'b010); check("rr_noplot", plot, 0);
    tick(); check("rr_gap2", gnt, 3'b000); check("rr_px1", x_out, 30); check("rr_py1", y_out, 40);
    tick(); check("rr_g3", gnt, 3'b100);
    tick(); check("rr_gap3", gnt, 3'b000); check("rr_px2", x_out, 50); check("rr_pc2", color_out, 3);
    tick(); check("rr_g4", gnt, 3'b001);
    req = '0; valid = '0; last = '0;
    tick(); check("abort_gnt", gnt, 3'b000); check("abort_plot", plot, 0);

    // Out-of-range drops and saturation, requester 1.
    req = 3'b010;
    tick(); check("drop_grant", gnt, 3'b010);
    valid = 3'b010; px[1] = 8'd160; py[1] = 7'd5;
    tick(); check("drop_x_plot", plot, 0); check("drop_x_cnt", drop_count, 1);
    px[1] = 8'd3; py[1] = 7'd120;
    tick(); check("drop_y_plot", plot, 0); check("drop_y_cnt", drop_count, 2);
    px[1] = 8'd200; py[1] = 7'd0;
    n_plot = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 299) last = 3'b010;
      tick();
      if (plot === 1'b1) n_plot++;
    end
    check("drop_sat", drop_count, 255);
    check("drop_no_plot", n_plot, 0);
    check("drop_last_gnt", gnt, 3'b000);
    check("drop_hold_x", x_out, 50);
    valid = '0; last = '0;

    // Idle timeout while requester 1 holds the grant; requester 2 waits.
    req = 3'b010;
    tick(); check("to_grant", gnt, 3'b010);
    req = 3'b110;
    bad_gnt = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (gnt !== 3'b010) bad_gnt++;
    end
    check("to_held", bad_gnt, 0);
    tick(); check("to_release", gnt, 3'b000);
    tick(); check("to_next", gnt, 3'b100);

    // Requester 2 drops req with a non-final valid pixel.
    req = 3'b010; valid = 3'b100; last = 3'b000; px[2] = 8'd1; py[2] = 7'd1;
    tick(); check("drop_req_gnt", gnt, 3'b000); check("drop_req_plot", plot, 0);
    check("drop_req_hold_x", x_out, 50);
    valid = '0;

    // Reset in the middle of a requester 1 burst, right after a plot.
    tick(); check("mid_grant", gnt, 3'b010);
    valid = 3'b010; px[1] = 8'd7; py[1] = 7'd8; pc[1] = 3'd5;
    tick(); check("mid_plot", plot, 1); check("mid_x", x_out, 7); check("mid_color", color_out, 5);
    reset = 1'b1;
    tick();
    check_zero_outputs("mid_reset");
    reset = 1'b0; req = 3'b111; valid = '0;
    tick(); check("post_reset_grant", gnt, 3'b001);
    req = '0;
    tick(); check("post_reset_abort", gnt, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 The block SHALL have parameter XMAX, default 159, giving the highest legal x coordinate.
REQ-002 The block SHALL have parameter YMAX, default 119, giving the highest legal y coordinate.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the idle cycles allowed in a granted burst before forced release.
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock; all logic samples on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, 3 bits: per-requester burst request (0 = black clear, 1 = colour fill, 2 = auxiliary).
REQ-007 The block SHALL have port valid, input, 3 bits: per-requester pixel valid.
REQ-008 The block SHALL have port last, input, 3 bits: per-requester final-pixel marker, qualified by valid.
REQ-009 The block SHALL have port x_in, input, 24 bits: x coordinate of requester i in bits [8i+7:8i].
REQ-010 The block SHALL have port y_in, input, 21 bits: y coordinate of requester i in bits [7i+6:7i].
REQ-011 The block SHALL have port color_in, input, 9 bits: colour of requester i in bits [3i+2:3i].
REQ-012 The block SHALL have port gnt, output, 3 bits: one-hot grant, registered.
REQ-013 The block SHALL have port plot, output, 1 bit: single-cycle write strobe to the VGA adapter.
REQ-014 The block SHALL have ports x (8 bits), y (7 bits) and color (3 bits), all outputs, giving the registered pixel presented with plot.
REQ-015 The block SHALL have port busy, output, 1 bit: high while any grant is held.
REQ-016 The block SHALL have port drop_count, output, 8 bits: saturating count of out-of-range pixels discarded.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-018 In IDLE with req nonzero, the block SHALL select one requester round-robin, enter GRANT and assert the matching gnt bit on the next edge.
REQ-019 Round-robin priority SHALL start at requester 0 after reset; after a burst by requester k, the highest priority SHALL be (k+1) mod 3.
REQ-020 In GRANT, valid/last/coordinates from non-granted requesters SHALL be ignored.
REQ-021 A granted valid pixel with x<=XMAX and y<=YMAX SHALL produce plot=1 with that x, y, color exactly one cycle later.
REQ-022 A granted valid pixel out of range SHALL NOT assert plot and SHALL increment drop_count, saturating at 255.
REQ-023 Granted valid&last SHALL end the burst: gnt cleared and IDLE entered on the next edge; the last pixel SHALL be plotted (or dropped) normally.
REQ-024 Deassertion of the granted req without last SHALL abort the burst: return to IDLE next edge with no plot for that cycle.
REQ-025 When the granted req drops in the same cycle as valid&last, the event SHALL be treated as a normal end and the pixel plotted.
REQ-026 An idle counter SHALL reset on each granted valid; on reaching TIMEOUT consecutive granted cycles without valid, the block SHALL release the grant and enter IDLE.
REQ-027 gnt SHALL be low for at least one cycle (IDLE) between consecutive bursts.
REQ-028 When plot=0, x, y and color SHALL hold their last values.
REQ-029 The gnt output SHALL never have more than one bit set, and busy SHALL equal |gnt.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL set state=IDLE, gnt=0, plot=0, x=0, y=0, color=0, busy=0, drop_count=0, idle counter=0 and round-robin priority to requester 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no further plot; a registered plot from the prior cycle SHALL NOT reappear.

Verification
REQ-032 Scenario: req=001 and requester 0 sweeps 160x120 with last on (159,119) -> 19200 plot pulses, each one cycle after valid, gnt=001 throughout, then gnt=000.
REQ-033 Scenario: req=111 held, each burst one pixel with last -> grant order 001, 010, 100, 001, with gnt=000 for one cycle between bursts.
REQ-034 Scenario: granted pixel x=160, y=5 then x=3, y=120 -> no plot and drop_count=2; 300 out-of-range pixels -> drop_count=255.
REQ-035 Scenario: requester 1 granted, valid held low 255 cycles -> gnt=000 on cycle 256 and requester 2 (if requesting) granted next.
REQ-036 Scenario: reset pulsed for one cycle during a requester 1 burst -> all outputs 0 next cycle, and the next grant goes to requester 0.
REQ-037 Scenario: requester 2 drops req with valid=1, last=0 -> no plot for that pixel and gnt=000 next cycle.
